// File: rtl/i2s_pkg.sv
// Shared I2S frame constants: 64-bit frame of two 32-bit slots, left slot first.
// Used by both the transmitter (i2s_p2s) and the mixer's receiver so the formats stay identical.
package i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int SLOT_CNT_W = 6;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

endpackage

// File: rtl/i2s_p2s_if.sv
// Parallel sample handshake between the mix engine (master) and the I2S transmitter (slave).
// valid/ready: a sample moves when sample_valid && sample_ready at a clock edge; the source must
// hold data_l/data_r/sample_valid stable until that edge, ready never depends on valid.
interface i2s_p2s_if #(
    parameter int bitNum = 16
);
    logic [bitNum-1:0] data_l;
    logic [bitNum-1:0] data_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output data_l,
        output data_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  data_l,
        input  data_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider and slot counter: clock_bit toggles every CLK_DIV system clocks, and each
// falling bit-clock edge (fall strobe) advances the 0..63 slot counter.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  bclk_o,
    output logic                  lr_o,
    output logic                  fall_o,
    output logic [SLOT_CNT_W-1:0] slot_next_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      div_q,  div_d;
    logic                  bclk_q, bclk_d;
    logic [SLOT_CNT_W-1:0] slot_q, slot_d;
    logic [SLOT_CNT_W-1:0] slot_inc;
    logic                  fall;

    always_comb begin
        div_d    = div_q + 1'b1;
        bclk_d   = bclk_q;
        slot_d   = slot_q;
        fall     = 1'b0;
        slot_inc = slot_q + 1'b1;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            fall   = bclk_q;
        end
        // 63 wraps to 0 naturally in the 6-bit counter
        if (fall) begin
            slot_d = slot_inc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            slot_q <= '1;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            slot_q <= slot_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign lr_o        = slot_q[SLOT_CNT_W-1];
    assign fall_o      = fall;
    assign slot_next_o = slot_inc;

endmodule

// File: rtl/i2s_p2s.sv
// I2S master transmitter: one-deep holding register fed by a valid/ready handshake, loaded into
// left/right shift registers at each frame start and shifted out MSB first one bit after LR edges.
module i2s_p2s
    import i2s_pkg::*;
#(
    parameter int bitNum  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic     clock,
    input  logic     reset_n,
    i2s_p2s_if.slave smp,
    output logic     clock_bit,
    output logic     clock_lr,
    output logic     data_out,
    output logic     frame_start,
    output logic     underrun
);

    logic                  fall;
    logic [SLOT_CNT_W-1:0] slot_next;
    logic                  load;
    logic [4:0]            pos;
    i2s_ch_e               ch;

    logic [bitNum-1:0] hold_l_q, hold_l_d;
    logic [bitNum-1:0] hold_r_q, hold_r_d;
    logic              full_q,   full_d;
    logic [bitNum-1:0] shl_q,    shl_d;
    logic [bitNum-1:0] shr_q,    shr_d;
    logic              dout_q,   dout_d;
    logic              fs_q,     fs_d;
    logic              ur_q,     ur_d;

    i2s_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .bclk_o      (clock_bit),
        .lr_o        (clock_lr),
        .fall_o      (fall),
        .slot_next_o (slot_next)
    );

    assign load = fall && (slot_next == '0);
    assign pos  = slot_next[4:0];
    assign ch   = i2s_ch_e'(slot_next[SLOT_CNT_W-1]);

    always_comb begin
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        full_d   = full_q;
        shl_d    = shl_q;
        shr_d    = shr_q;
        dout_d   = dout_q;
        fs_d     = 1'b0;
        ur_d     = 1'b0;

        if (fall) begin
            // Bit position 0 of each slot is the I2S one-bit delay; drained shift regs give 0 past bitNum
            dout_d = 1'b0;
            if (load) begin
                fs_d = 1'b1;
                if (full_q) begin
                    shl_d  = hold_l_q;
                    shr_d  = hold_r_q;
                    full_d = 1'b0;
                end else begin
                    shl_d = '0;
                    shr_d = '0;
                    ur_d  = 1'b1;
                end
            end else if (pos != 5'd0) begin
                if (ch == CH_RIGHT) begin
                    dout_d = shr_q[bitNum-1];
                    shr_d  = shr_q << 1;
                end else begin
                    dout_d = shl_q[bitNum-1];
                    shl_d  = shl_q << 1;
                end
            end
        end

        // Capture is evaluated after the load so a same-cycle write fills holding for the next frame
        if (smp.sample_valid && !full_q) begin
            hold_l_d = smp.data_l;
            hold_r_d = smp.data_r;
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
            full_q   <= 1'b0;
            shl_q    <= '0;
            shr_q    <= '0;
            dout_q   <= 1'b0;
            fs_q     <= 1'b0;
            ur_q     <= 1'b0;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            full_q   <= full_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            dout_q   <= dout_d;
            fs_q     <= fs_d;
            ur_q     <= ur_d;
        end
    end

    assign smp.sample_ready = ~full_q;
    assign data_out         = dout_q;
    assign frame_start      = fs_q;
    assign underrun         = ur_q;

endmodule

// File: tb/tb_i2s_p2s.sv
// Directed bench for i2s_p2s: a 16-bit/CLK_DIV=2 instance and a 24-bit/CLK_DIV=3 instance,
// with a bit-clock-driven frame receiver and hand-computed 64-bit frame images.
module tb_i2s_p2s;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  logic        sel;
  logic [23:0] drv_l, drv_r;
  logic        drv_valid;

  i2s_p2s_if #(.bitNum(16)) if_a ();
  i2s_p2s_if #(.bitNum(24)) if_b ();

  assign if_a.data_l       = drv_l[15:0];
  assign if_a.data_r       = drv_r[15:0];
  assign if_a.sample_valid = drv_valid & ~sel;
  assign if_b.data_l       = drv_l;
  assign if_b.data_r       = drv_r;
  assign if_b.sample_valid = drv_valid & sel;

  logic bclk_a, lr_a, dout_a, fs_a, ur_a;
  logic bclk_b, lr_b, dout_b, fs_b, ur_b;

  i2s_p2s #(.bitNum(16), .CLK_DIV(2)) dut_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .smp         (if_a),
    .clock_bit   (bclk_a),
    .clock_lr    (lr_a),
    .data_out    (dout_a),
    .frame_start (fs_a),
    .underrun    (ur_a)
  );

  i2s_p2s #(.bitNum(24), .CLK_DIV(3)) dut_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .smp         (if_b),
    .clock_bit   (bclk_b),
    .clock_lr    (lr_b),
    .data_out    (dout_b),
    .frame_start (fs_b),
    .underrun    (ur_b)
  );

  logic m_bclk, m_lr, m_dout, m_fs, m_ur, m_ready;
  assign m_bclk  = sel ? bclk_b : bclk_a;
  assign m_lr    = sel ? lr_b   : lr_a;
  assign m_dout  = sel ? dout_b : dout_a;
  assign m_fs    = sel ? fs_b   : fs_a;
  assign m_ur    = sel ? ur_b   : ur_a;
  assign m_ready = sel ? if_b.sample_ready : if_a.sample_ready;

  int cdiv;
  assign cdiv = sel ? 3 : 2;

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_sample(input logic [23:0] l, input logic [23:0] r, output int waited);
    waited = 0;
    drv_l = l;
    drv_r = r;
    drv_valid = 1'b1;
    while (!m_ready && waited < 1000) begin
      @(negedge clock);
      waited++;
    end
    check("write_accept", {63'd0, m_ready}, 64'd1);
    @(negedge clock);
    drv_valid = 1'b0;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_fs && n < 128 * cdiv + 16);
    check("fs_seen", {63'd0, m_fs}, 64'd1);
  endtask

  // Waits for the next frame_start, then samples data_out on 64 bit-clock rises.
  task automatic capture_frame(output logic [63:0] f, output int n_ur, output int lr_bad,
                               output bit ok);
    int w;
    logic prev;
    f = '0;
    n_ur = 0;
    lr_bad = 0;
    ok = 1'b1;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!m_fs && w < 128 * cdiv + 16);
    if (!m_fs) begin
      ok = 1'b0;
      return;
    end
    n_ur += int'(m_ur);
    prev = m_bclk;
    for (int k = 0; k < 64; k++) begin
      w = 0;
      do begin
        prev = m_bclk;
        @(negedge clock);
        w++;
        n_ur += int'(m_ur);
      end while (!(m_bclk && !prev) && w < 4 * cdiv + 4);
      if (!(m_bclk && !prev)) begin
        ok = 1'b0;
        return;
      end
      f[63-k] = m_dout;
      if (m_lr !== (k >= 32)) lr_bad++;
    end
  endtask

  task automatic frame_check(input string name, input logic [63:0] exp, input int exp_ur);
    logic [63:0] f;
    int n_ur, lr_bad;
    bit ok;
    capture_frame(f, n_ur, lr_bad, ok);
    check({name, "_done"}, {63'd0, ok}, 64'd1);
    check(name, f, exp);
    check({name, "_ur"}, 64'(n_ur), 64'(exp_ur));
    check({name, "_lr"}, 64'(lr_bad), 64'd0);
  endtask

  task automatic period_check(input int exp_clocks);
    int n;
    wait_fs(n);
    wait_fs(n);
    check("frame_period", 64'(n), 64'(exp_clocks));
  endtask

  // Resets in the middle of slot 40 (bit clock high), then checks recovery and a clean frame.
  task automatic mid_reset(input logic [23:0] l, input logic [23:0] r, input logic [63:0] exp);
    int n, waited;
    wait_fs(n);
    write_sample(24'h000fff, 24'hfff000, waited);
    repeat (81 * cdiv - 1) @(negedge clock);
    check("pre_rst_bclk_ready", {62'd0, m_bclk, m_ready}, 64'b10);
    check("pre_rst_lr", {63'd0, m_lr}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {58'd0, m_bclk, m_lr, m_dout, m_fs, m_ur, m_ready}, 64'b010001);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_fs && n < 50);
    check("rst_first_fs", 64'(n), 64'(2 * cdiv));
    check("rst_first_ur", {63'd0, m_ur}, 64'd1);
    write_sample(l, r, waited);
    frame_check("clean_frame", exp, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, waited;
    logic [63:0] f;
    int n_ur, lr_bad;
    bit ok;

    vecs[0] = '{24'h00A5C3, 24'h008001, 64'h52E18000_40008000};
    vecs[1] = '{24'h000000, 24'h00FFFF, 64'h00000000_7FFF8000};
    vecs[2] = '{24'h007FFF, 24'h008000, 64'h3FFF8000_40000000};
    vecs[3] = '{24'h001234, 24'h00FEDC, 64'h091A0000_7F6E0000};

    total = 0;
    bad = 0;
    sel = 1'b0;
    drv_l = '0;
    drv_r = '0;
    drv_valid = 1'b0;
    reset_n = 1'b0;

    // Reset state and release timing
    repeat (3) @(negedge clock);
    check("rst_outputs", {58'd0, m_bclk, m_lr, m_dout, m_fs, m_ur, m_ready}, 64'b010001);
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_bclk_1", {63'd0, m_bclk}, 64'd0);
    @(negedge clock);
    check("rel_bclk_2", {63'd0, m_bclk}, 64'd1);
    @(negedge clock);
    check("rel_lr_3", {62'd0, m_lr, m_fs}, 64'b10);
    @(negedge clock);
    check("rel_4", {60'd0, m_bclk, m_lr, m_fs, m_ur}, 64'b0011);

    // Table-driven single frames (holding is empty right after each load)
    foreach (vecs[i]) begin
      write_sample(vecs[i].l, vecs[i].r, waited);
      check("ready_after_write", {63'd0, m_ready}, 64'd0);
      exp_q.push_back(vecs[i].exp);
      frame_check("vec_frame", exp_q.pop_front(), 0);
    end

    period_check(256);

    // Underrun: no write for a whole frame
    frame_check("underrun_frame", 64'd0, 1);

    // Back-pressure: second sample waits for the frame load
    wait_fs(n);
    exp_q.push_back(64'h07878000_78780000);
    exp_q.push_back(64'h1E1E0000_61E18000);
    fork
      begin
        capture_frame(f, n_ur, lr_bad, ok);
      end
      begin
        int w1, w2;
        write_sample(24'h000F0F, 24'h00F0F0, w1);
        check("bp_ready_low", {63'd0, m_ready}, 64'd0);
        write_sample(24'h003C3C, 24'h00C3C3, w2);
        check("bp_waited", 64'(w2 > 100), 64'd1);
      end
    join
    check("bp_frame1_done", {63'd0, ok}, 64'd1);
    check("bp_frame1", f, exp_q.pop_front());
    check("bp_frame1_ur", 64'(n_ur), 64'd0);
    frame_check("bp_frame2", exp_q.pop_front(), 0);

    // Collision: valid in the exact load cycle with holding empty
    wait_fs(n);
    fork
      begin
        capture_frame(f, n_ur, lr_bad, ok);
      end
      begin
        repeat (128 * cdiv - 1) @(negedge clock);
        drv_l = 24'h005555;
        drv_r = 24'h00AAAA;
        drv_valid = 1'b1;
        @(negedge clock);
        drv_valid = 1'b0;
        check("col_pulses", {61'd0, m_fs, m_ur, m_ready}, 64'b110);
      end
    join
    check("col_frame_done", {63'd0, ok}, 64'd1);
    check("col_zero_frame", f, 64'd0);
    check("col_zero_ur", 64'(n_ur), 64'd1);
    frame_check("col_next_frame", 64'h2AAA8000_55550000, 0);

    // Mid-frame reset on the 16-bit instance
    mid_reset(24'h006996, 24'h001EE1, 64'h34CB0000_0F708000);

    // 24-bit, CLK_DIV=3 instance
    sel = 1'b1;
    period_check(384);
    wait_fs(n);
    write_sample(24'hA5C3E7, 24'h800001, waited);
    frame_check("b_frame", 64'h52E1F380_40000080, 0);
    mid_reset(24'h123456, 24'hFEDCBA, 64'h091A2B00_7F6E5D00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
